fu_complete_arbiter: RTL and testbench

- Sits between the six functional units (ALU_1..3, MULT_1..2, BRANCH) and the single complete/CDB port.
- Each FU hands a finished result to its own one-entry holding slot over a valid/ready handshake.
- A round-robin arbiter drains one slot per cycle into a registered complete packet, with backpressure from the complete stage and a squash from branch recovery.
- Also drives per-FU stall to the RS and a dispatch stall.

---
 rtl/fu_complete_arbiter.sv | 173 +++++++++++++++++
 tb/tb_fu_complete_arbiter.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fu_complete_arbiter.sv
// Complete-stage arbiter: one holding slot per functional unit, drained
// round-robin into a registered complete packet with backpressure and squash.
module fu_complete_arbiter #(
  parameter int NUM_FU       = 6,
  parameter int DATA_W       = 32,
  parameter int TAG_W        = 6,
  parameter int ROB_W        = 5,
  parameter int STALL_THRESH = 2
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [NUM_FU-1:0]        fu_valid,
  output logic [NUM_FU-1:0]        fu_ready,
  input  logic [NUM_FU*DATA_W-1:0] fu_data,
  input  logic [NUM_FU*TAG_W-1:0]  fu_tag,
  input  logic [NUM_FU*ROB_W-1:0]  fu_rob,
  input  logic [NUM_FU-1:0]        fu_take_branch,
  input  logic                     squash,
  input  logic                     cmp_ready,
  output logic                     cmp_valid,
  output logic [2:0]               cmp_fu,
  output logic [DATA_W-1:0]        cmp_data,
  output logic [TAG_W-1:0]         cmp_tag,
  output logic [ROB_W-1:0]         cmp_rob,
  output logic                     cmp_take_branch,
  output logic [NUM_FU-1:0]        fu_rs_stall,
  output logic                     dispatch_stall,
  output logic [2:0]               occupancy
);

  localparam logic [2:0] BRANCH_IDX = 3'(NUM_FU - 1);

  logic [NUM_FU-1:0]             slot_valid_q, slot_valid_d;
  logic [NUM_FU-1:0][DATA_W-1:0] slot_data_q, slot_data_d;
  logic [NUM_FU-1:0][TAG_W-1:0]  slot_tag_q, slot_tag_d;
  logic [NUM_FU-1:0][ROB_W-1:0]  slot_rob_q, slot_rob_d;
  logic [NUM_FU-1:0]             slot_tb_q, slot_tb_d;

  logic [2:0]        rr_ptr_q, rr_ptr_d;
  logic              cmp_valid_q, cmp_valid_d;
  logic [2:0]        cmp_fu_q, cmp_fu_d;
  logic [DATA_W-1:0] cmp_data_q, cmp_data_d;
  logic [TAG_W-1:0]  cmp_tag_q, cmp_tag_d;
  logic [ROB_W-1:0]  cmp_rob_q, cmp_rob_d;
  logic              cmp_tb_q, cmp_tb_d;
  logic [2:0]        occupancy_q, occupancy_d;

  logic              load_ok;
  logic              hi_found, lo_found;
  logic [2:0]        hi_idx, lo_idx;
  logic              grant_any;
  logic [2:0]        grant_idx;
  logic [NUM_FU-1:0] grant;

  // Round-robin pick: lowest valid index at or above rr_ptr, else lowest valid overall.
  always_comb begin
    load_ok  = !cmp_valid_q || cmp_ready;
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = NUM_FU - 1; i >= 0; i--) begin
      if (slot_valid_q[i]) begin
        lo_found = 1'b1;
        lo_idx   = 3'(i);
        if (3'(i) >= rr_ptr_q) begin
          hi_found = 1'b1;
          hi_idx   = 3'(i);
        end
      end
    end
    grant_idx = hi_found ? hi_idx : lo_idx;
    grant_any = lo_found && load_ok && !squash;
    grant     = grant_any ? ({{(NUM_FU-1){1'b0}}, 1'b1} << grant_idx) : '0;
  end

  assign fu_ready    = {NUM_FU{!squash}} & (~slot_valid_q | grant);
  assign fu_rs_stall = slot_valid_q & ~grant;

  always_comb begin
    slot_valid_d = slot_valid_q;
    slot_data_d  = slot_data_q;
    slot_tag_d   = slot_tag_q;
    slot_rob_d   = slot_rob_q;
    slot_tb_d    = slot_tb_q;
    for (int i = 0; i < NUM_FU; i++) begin
      if (grant[i]) begin
        slot_valid_d[i] = 1'b0;
      end
      if (fu_valid[i] && fu_ready[i]) begin
        slot_valid_d[i] = 1'b1;
        slot_data_d[i]  = fu_data[i*DATA_W +: DATA_W];
        slot_tag_d[i]   = fu_tag[i*TAG_W +: TAG_W];
        slot_rob_d[i]   = fu_rob[i*ROB_W +: ROB_W];
        slot_tb_d[i]    = fu_take_branch[i];
      end
    end
    if (squash) begin
      slot_valid_d = '0;
    end

    occupancy_d = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      occupancy_d = occupancy_d + 3'(slot_valid_d[i]);
    end
  end

  // Packet register: loads the granted slot, empties when nothing is pending.
  always_comb begin
    cmp_valid_d = cmp_valid_q;
    cmp_fu_d    = cmp_fu_q;
    cmp_data_d  = cmp_data_q;
    cmp_tag_d   = cmp_tag_q;
    cmp_rob_d   = cmp_rob_q;
    cmp_tb_d    = cmp_tb_q;
    rr_ptr_d    = rr_ptr_q;
    if (squash) begin
      cmp_valid_d = 1'b0;
    end else if (grant_any) begin
      cmp_valid_d = 1'b1;
      cmp_fu_d    = grant_idx;
      cmp_data_d  = slot_data_q[grant_idx];
      cmp_tag_d   = slot_tag_q[grant_idx];
      cmp_rob_d   = slot_rob_q[grant_idx];
      cmp_tb_d    = (grant_idx == BRANCH_IDX) && slot_tb_q[grant_idx];
      rr_ptr_d    = (grant_idx == BRANCH_IDX) ? 3'd0 : grant_idx + 3'd1;
    end else if (load_ok) begin
      cmp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      slot_valid_q <= '0;
      slot_data_q  <= '0;
      slot_tag_q   <= '0;
      slot_rob_q   <= '0;
      slot_tb_q    <= '0;
      rr_ptr_q     <= '0;
      cmp_valid_q  <= 1'b0;
      cmp_fu_q     <= '0;
      cmp_data_q   <= '0;
      cmp_tag_q    <= '0;
      cmp_rob_q    <= '0;
      cmp_tb_q     <= 1'b0;
      occupancy_q  <= '0;
    end else begin
      slot_valid_q <= slot_valid_d;
      slot_data_q  <= slot_data_d;
      slot_tag_q   <= slot_tag_d;
      slot_rob_q   <= slot_rob_d;
      slot_tb_q    <= slot_tb_d;
      rr_ptr_q     <= rr_ptr_d;
      cmp_valid_q  <= cmp_valid_d;
      cmp_fu_q     <= cmp_fu_d;
      cmp_data_q   <= cmp_data_d;
      cmp_tag_q    <= cmp_tag_d;
      cmp_rob_q    <= cmp_rob_d;
      cmp_tb_q     <= cmp_tb_d;
      occupancy_q  <= occupancy_d;
    end
  end

  assign cmp_valid       = cmp_valid_q;
  assign cmp_fu          = cmp_fu_q;
  assign cmp_data        = cmp_data_q;
  assign cmp_tag         = cmp_tag_q;
  assign cmp_rob         = cmp_rob_q;
  assign cmp_take_branch = cmp_tb_q;
  assign occupancy       = occupancy_q;
  assign dispatch_stall  = (occupancy_q >= 3'(STALL_THRESH));

endmodule

// File: tb/tb_fu_complete_arbiter.sv
// Directed self-checking bench for fu_complete_arbiter: latency, round-robin
// order, backpressure, squash and asynchronous reset.
module tb_fu_complete_arbiter;

  localparam int NUM_FU = 6;
  localparam int DATA_W = 32;
  localparam int TAG_W  = 6;
  localparam int ROB_W  = 5;

  logic                     clock = 1'b0;
  logic                     reset_n;
  logic [NUM_FU-1:0]        fu_valid;
  logic [NUM_FU-1:0]        fu_ready;
  logic [NUM_FU*DATA_W-1:0] fu_data;
  logic [NUM_FU*TAG_W-1:0]  fu_tag;
  logic [NUM_FU*ROB_W-1:0]  fu_rob;
  logic [NUM_FU-1:0]        fu_take_branch;
  logic                     squash;
  logic                     cmp_ready;
  logic                     cmp_valid;
  logic [2:0]               cmp_fu;
  logic [DATA_W-1:0]        cmp_data;
  logic [TAG_W-1:0]         cmp_tag;
  logic [ROB_W-1:0]         cmp_rob;
  logic                     cmp_take_branch;
  logic [NUM_FU-1:0]        fu_rs_stall;
  logic                     dispatch_stall;
  logic [2:0]               occupancy;

  logic [47:0] pkt;
  logic [47:0] exp_pkt;
  int checks = 0;
  int passes = 0;

  assign pkt = {cmp_valid, cmp_fu, cmp_data, cmp_tag, cmp_rob, cmp_take_branch};

  fu_complete_arbiter dut (
    .clock(clock), .reset_n(reset_n),
    .fu_valid(fu_valid), .fu_ready(fu_ready),
    .fu_data(fu_data), .fu_tag(fu_tag), .fu_rob(fu_rob),
    .fu_take_branch(fu_take_branch),
    .squash(squash), .cmp_ready(cmp_ready),
    .cmp_valid(cmp_valid), .cmp_fu(cmp_fu), .cmp_data(cmp_data),
    .cmp_tag(cmp_tag), .cmp_rob(cmp_rob), .cmp_take_branch(cmp_take_branch),
    .fu_rs_stall(fu_rs_stall), .dispatch_stall(dispatch_stall),
    .occupancy(occupancy)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic set_fu(input int i, input logic [31:0] d, input logic [5:0] t,
                        input logic [4:0] r, input logic b);
    fu_data[i*DATA_W +: DATA_W] = d;
    fu_tag[i*TAG_W +: TAG_W]    = t;
    fu_rob[i*ROB_W +: ROB_W]    = r;
    fu_take_branch[i]           = b;
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    fu_valid  = '0;
    squash    = 1'b0;
    cmp_ready = 1'b1;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n        = 1'b0;
    fu_valid       = '0;
    fu_data        = '0;
    fu_tag         = '0;
    fu_rob         = '0;
    fu_take_branch = '0;
    squash         = 1'b0;
    cmp_ready      = 1'b1;
    #13;
    checks++;
    if (pkt !== 48'h0) $display("[TB] FAIL reset_pkt: got %h expected %h", pkt, 48'h0);
    else passes++;
    checks++;
    if ({occupancy, dispatch_stall} !== 4'b0000)
      $display("[TB] FAIL reset_occ: got occ=%0d stall=%b expected 0/0", occupancy, dispatch_stall);
    else passes++;
    checks++;
    if ({fu_ready, fu_rs_stall} !== {6'h3F, 6'h00})
      $display("[TB] FAIL reset_ready: got ready=%b rs_stall=%b expected 111111/000000", fu_ready, fu_rs_stall);
    else passes++;
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_single();
    next_cycle();
    set_fu(0, 32'h0000_00AA, 6'd7, 5'd3, 1'b0);
    fu_valid = 6'b000001;
    @(negedge clock);
    checks++;
    if (fu_ready !== 6'h3F) $display("[TB] FAIL single_ready0: got %b expected 111111", fu_ready);
    else passes++;

    next_cycle();
    fu_valid = '0;
    @(negedge clock);
    checks++;
    if ({cmp_valid, occupancy, fu_ready} !== {1'b0, 3'd1, 6'h3F})
      $display("[TB] FAIL single_c1: got valid=%b occ=%0d ready=%b expected 0/1/111111", cmp_valid, occupancy, fu_ready);
    else passes++;

    next_cycle();
    @(negedge clock);
    exp_pkt = {1'b1, 3'd0, 32'h0000_00AA, 6'd7, 5'd3, 1'b0};
    checks++;
    if (pkt !== exp_pkt) $display("[TB] FAIL single_pkt: got %h expected %h", pkt, exp_pkt);
    else passes++;
    checks++;
    if ({occupancy, fu_ready} !== {3'd0, 6'h3F})
      $display("[TB] FAIL single_c2: got occ=%0d ready=%b expected 0/111111", occupancy, fu_ready);
    else passes++;

    next_cycle();
    @(negedge clock);
    checks++;
    if (cmp_valid !== 1'b0) $display("[TB] FAIL single_drop: got cmp_valid=%b expected 0", cmp_valid);
    else passes++;
  endtask

  task automatic test_all_six();
    do_reset();
    next_cycle();
    for (int i = 0; i < NUM_FU; i++)
      set_fu(i, 32'h1000_0000 + i, 6'(10 + i), 5'(20 + i), 1'b1);
    fu_valid = 6'h3F;
    @(negedge clock);
    for (int k = 0; k <= NUM_FU; k++) begin
      next_cycle();
      fu_valid = '0;
      @(negedge clock);
      checks++;
      if ({occupancy, dispatch_stall} !== {3'(6 - k), (6 - k) >= 2})
        $display("[TB] FAIL six_occ%0d: got occ=%0d stall=%b expected %0d/%b",
                 k, occupancy, dispatch_stall, 6 - k, (6 - k) >= 2);
      else passes++;
      if (k >= 1) begin
        exp_pkt = {1'b1, 3'(k - 1), 32'h1000_0000 + 32'(k - 1), 6'(9 + k), 5'(19 + k), (k - 1) == 5};
        checks++;
        if (pkt !== exp_pkt) $display("[TB] FAIL six_pkt%0d: got %h expected %h", k - 1, pkt, exp_pkt);
        else passes++;
      end
    end
    next_cycle();
    @(negedge clock);
    checks++;
    if (cmp_valid !== 1'b0) $display("[TB] FAIL six_drain: got cmp_valid=%b expected 0", cmp_valid);
    else passes++;
  endtask

  task automatic test_rr_wrap();
    next_cycle();
    set_fu(1, 32'h11, 6'd1, 5'd1, 1'b0);
    fu_valid = 6'b000010;
    next_cycle();
    fu_valid = '0;
    next_cycle();
    @(negedge clock);
    exp_pkt = {1'b1, 3'd1, 32'h11, 6'd1, 5'd1, 1'b0};
    checks++;
    if (pkt !== exp_pkt) $display("[TB] FAIL rr_prime: got %h expected %h", pkt, exp_pkt);
    else passes++;

    next_cycle();
    set_fu(1, 32'h21, 6'd2, 5'd2, 1'b0);
    set_fu(4, 32'h24, 6'd4, 5'd4, 1'b1);
    fu_valid = 6'b010010;
    next_cycle();
    fu_valid = '0;
    @(negedge clock);
    checks++;
    if (occupancy !== 3'd2) $display("[TB] FAIL rr_occ: got %0d expected 2", occupancy);
    else passes++;
    next_cycle();
    @(negedge clock);
    exp_pkt = {1'b1, 3'd4, 32'h24, 6'd4, 5'd4, 1'b0};
    checks++;
    if (pkt !== exp_pkt) $display("[TB] FAIL rr_first4: got %h expected %h", pkt, exp_pkt);
    else passes++;
    next_cycle();
    @(negedge clock);
    exp_pkt = {1'b1, 3'd1, 32'h21, 6'd2, 5'd2, 1'b0};
    checks++;
    if (pkt !== exp_pkt) $display("[TB] FAIL rr_then1: got %h expected %h", pkt, exp_pkt);
    else passes++;

    next_cycle();
    set_fu(0, 32'h30, 6'd30, 5'd0, 1'b0);
    set_fu(3, 32'h33, 6'd33, 5'd3, 1'b0);
    fu_valid = 6'b001001;
    next_cycle();
    fu_valid = '0;
    next_cycle();
    @(negedge clock);
    exp_pkt = {1'b1, 3'd3, 32'h33, 6'd33, 5'd3, 1'b0};
    checks++;
    if (pkt !== exp_pkt) $display("[TB] FAIL rr_ptr2_first3: got %h expected %h", pkt, exp_pkt);
    else passes++;
    next_cycle();
    @(negedge clock);
    exp_pkt = {1'b1, 3'd0, 32'h30, 6'd30, 5'd0, 1'b0};
    checks++;
    if (pkt !== exp_pkt) $display("[TB] FAIL rr_ptr2_then0: got %h expected %h", pkt, exp_pkt);
    else passes++;
    next_cycle();
  endtask

  task automatic test_backpressure();
    cmp_ready = 1'b1;
    next_cycle();
    set_fu(3, 32'hB1, 6'd11, 5'd11, 1'b0);
    fu_valid = 6'b001000;
    next_cycle();
    set_fu(3, 32'hB2, 6'd12, 5'd12, 1'b0);
    @(negedge clock);
    checks++;
    if ({fu_ready[3], fu_rs_stall[3]} !== 2'b10)
      $display("[TB] FAIL bp_refill: got ready3=%b rs_stall3=%b expected 1/0", fu_ready[3], fu_rs_stall[3]);
    else passes++;

    for (int c = 0; c < 3; c++) begin
      next_cycle();
      set_fu(3, 32'hB3, 6'd13, 5'd13, 1'b0);
      cmp_ready = 1'b0;
      @(negedge clock);
      exp_pkt = {1'b1, 3'd3, 32'hB1, 6'd11, 5'd11, 1'b0};
      checks++;
      if (pkt !== exp_pkt) $display("[TB] FAIL bp_hold%0d: got %h expected %h", c, pkt, exp_pkt);
      else passes++;
      checks++;
      if ({fu_ready[3], fu_rs_stall[3], occupancy} !== {2'b01, 3'd1})
        $display("[TB] FAIL bp_stall%0d: got ready3=%b rs_stall3=%b occ=%0d expected 0/1/1",
                 c, fu_ready[3], fu_rs_stall[3], occupancy);
      else passes++;
    end

    next_cycle();
    cmp_ready = 1'b1;
    @(negedge clock);
    checks++;
    if ({fu_ready[3], fu_rs_stall[3]} !== 2'b10)
      $display("[TB] FAIL bp_release: got ready3=%b rs_stall3=%b expected 1/0", fu_ready[3], fu_rs_stall[3]);
    else passes++;
    next_cycle();
    fu_valid = '0;
    @(negedge clock);
    exp_pkt = {1'b1, 3'd3, 32'hB2, 6'd12, 5'd12, 1'b0};
    checks++;
    if (pkt !== exp_pkt || occupancy !== 3'd1)
      $display("[TB] FAIL bp_next: got %h occ=%0d expected %h occ=1", pkt, occupancy, exp_pkt);
    else passes++;
    next_cycle();
    @(negedge clock);
    exp_pkt = {1'b1, 3'd3, 32'hB3, 6'd13, 5'd13, 1'b0};
    checks++;
    if (pkt !== exp_pkt || occupancy !== 3'd0)
      $display("[TB] FAIL bp_last: got %h occ=%0d expected %h occ=0", pkt, occupancy, exp_pkt);
    else passes++;
    next_cycle();
  endtask

  task automatic test_squash();
    cmp_ready = 1'b1;
    next_cycle();
    set_fu(0, 32'hC0, 6'd40, 5'd0, 1'b0);
    set_fu(1, 32'hC1, 6'd41, 5'd1, 1'b0);
    set_fu(2, 32'hC2, 6'd42, 5'd2, 1'b0);
    set_fu(5, 32'hC5, 6'd45, 5'd5, 1'b1);
    fu_valid = 6'b100111;
    next_cycle();
    set_fu(3, 32'hC3, 6'd43, 5'd3, 1'b0);
    fu_valid = 6'b001000;
    squash   = 1'b1;
    @(negedge clock);
    checks++;
    if ({occupancy, dispatch_stall, fu_ready} !== {3'd4, 1'b1, 6'h00})
      $display("[TB] FAIL sq_during: got occ=%0d stall=%b ready=%b expected 4/1/000000",
               occupancy, dispatch_stall, fu_ready);
    else passes++;

    next_cycle();
    squash   = 1'b0;
    fu_valid = '0;
    @(negedge clock);
    checks++;
    if ({occupancy, cmp_valid, dispatch_stall, fu_ready} !== {3'd0, 1'b0, 1'b0, 6'h3F})
      $display("[TB] FAIL sq_after: got occ=%0d valid=%b stall=%b ready=%b expected 0/0/0/111111",
               occupancy, cmp_valid, dispatch_stall, fu_ready);
    else passes++;
    next_cycle();
    @(negedge clock);
    checks++;
    if ({occupancy, cmp_valid} !== {3'd0, 1'b0})
      $display("[TB] FAIL sq_nocapture: got occ=%0d valid=%b expected 0/0", occupancy, cmp_valid);
    else passes++;

    next_cycle();
    set_fu(0, 32'hD0, 6'd50, 5'd10, 1'b1);
    set_fu(5, 32'hD5, 6'd55, 5'd15, 1'b1);
    fu_valid = 6'b100001;
    next_cycle();
    fu_valid = '0;
    next_cycle();
    @(negedge clock);
    exp_pkt = {1'b1, 3'd5, 32'hD5, 6'd55, 5'd15, 1'b1};
    checks++;
    if (pkt !== exp_pkt) $display("[TB] FAIL sq_rr_kept5: got %h expected %h", pkt, exp_pkt);
    else passes++;
    next_cycle();
    @(negedge clock);
    exp_pkt = {1'b1, 3'd0, 32'hD0, 6'd50, 5'd10, 1'b0};
    checks++;
    if (pkt !== exp_pkt) $display("[TB] FAIL sq_then0_tb0: got %h expected %h", pkt, exp_pkt);
    else passes++;
    next_cycle();
  endtask

  task automatic test_async_reset();
    next_cycle();
    set_fu(0, 32'hE0, 6'd60, 5'd0, 1'b0);
    set_fu(1, 32'hE1, 6'd61, 5'd1, 1'b0);
    set_fu(2, 32'hE2, 6'd62, 5'd2, 1'b0);
    set_fu(3, 32'hE3, 6'd63, 5'd3, 1'b0);
    fu_valid  = 6'b001111;
    cmp_ready = 1'b0;
    next_cycle();
    fu_valid = '0;
    next_cycle();
    @(negedge clock);
    checks++;
    if ({cmp_valid, occupancy} !== {1'b1, 3'd3})
      $display("[TB] FAIL ar_setup: got valid=%b occ=%0d expected 1/3", cmp_valid, occupancy);
    else passes++;
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (pkt !== 48'h0 || occupancy !== 3'd0 || dispatch_stall !== 1'b0)
      $display("[TB] FAIL ar_immediate: got pkt=%h occ=%0d stall=%b expected 0/0/0", pkt, occupancy, dispatch_stall);
    else passes++;
    checks++;
    if ({fu_ready, fu_rs_stall} !== {6'h3F, 6'h00})
      $display("[TB] FAIL ar_ready: got ready=%b rs_stall=%b expected 111111/000000", fu_ready, fu_rs_stall);
    else passes++;
    @(negedge clock);
    reset_n   = 1'b1;
    cmp_ready = 1'b1;
    next_cycle();
    @(negedge clock);
    checks++;
    if ({cmp_valid, occupancy} !== {1'b0, 3'd0})
      $display("[TB] FAIL ar_after: got valid=%b occ=%0d expected 0/0", cmp_valid, occupancy);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_six();
    test_rr_wrap();
    test_backpressure();
    test_squash();
    test_async_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
